// File: rtl/ps2_host_ctrl.sv
// PS/2 keyboard host: conditioned pin receive into a show-ahead scan-code FIFO,
// plus optional host-to-device command transmission compiled in with PS2_TX_EN.
module ps2_host_ctrl #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_error,
  output logic       rx_overflow,
  input  logic       ovf_clr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_ack_err
);

  localparam longint unsigned TO_CYC = (64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam int unsigned     TW     = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0]   TO_CNT = TW'(TO_CYC);
  localparam int unsigned     AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX
`ifdef PS2_TX_EN
    , S_TX_INH, S_TX_START, S_TX_BITS, S_TX_ACK
`endif
  } state_t;

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_filt_q;
  logic [2:0] filt_cnt_q;
  logic       fe, dat_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == 3'd7) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 3'd1;
      end
    end
  end

  // fe is asserted in the cycle whose edge commits the filtered 1->0 change
  assign fe    = clk_filt_q && !clk_sync_q[1] && (filt_cnt_q == 3'd7);
  assign dat_s = dat_sync_q[1];

  state_t        state_q;
  logic [3:0]    bitcnt_q;
  logic [8:0]    rx_sh_q;
  logic [TW-1:0] timer_q;
  logic          rx_err_q;
  logic          timed, timeout, frame_good;

`ifdef PS2_TX_EN
  localparam int unsigned INH_CYC = CLK_HZ / 10000;
  localparam int unsigned IW      = (INH_CYC > 1) ? $clog2(INH_CYC) : 1;
  logic [8:0]    tx_sh_q;
  logic [IW-1:0] inh_q;
  logic          clk_oe_q, dat_oe_q, ack_err_q;
`endif

  always_comb begin
    timed = (state_q == S_RX)
`ifdef PS2_TX_EN
            || (state_q == S_TX_BITS) || (state_q == S_TX_ACK)
`endif
            ;
    timeout    = (timer_q == TO_CNT);
    frame_good = (state_q == S_RX) && fe && (bitcnt_q == 4'd9) && dat_s && (^rx_sh_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      rx_sh_q  <= '0;
      timer_q  <= '0;
      rx_err_q <= 1'b0;
`ifdef PS2_TX_EN
      tx_sh_q   <= '0;
      inh_q     <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ack_err_q <= 1'b0;
`endif
    end else begin
      rx_err_q <= 1'b0;
`ifdef PS2_TX_EN
      ack_err_q <= 1'b0;
`endif
      timer_q <= (fe || !timed) ? '0 : timer_q + TW'(1);
      case (state_q)
        S_IDLE: begin
          bitcnt_q <= '0;
          if (fe) begin
            if (dat_s) rx_err_q <= 1'b1;
            else       state_q  <= S_RX;
          end
`ifdef PS2_TX_EN
          else if (tx_valid) begin
            tx_sh_q  <= {~^tx_data, tx_data};
            inh_q    <= '0;
            clk_oe_q <= 1'b1;
            state_q  <= S_TX_INH;
          end
`endif
        end
        S_RX: begin
          if (fe) begin
            if (bitcnt_q == 4'd9) begin
              rx_err_q <= !frame_good;
              state_q  <= S_IDLE;
            end else begin
              rx_sh_q  <= {dat_s, rx_sh_q[8:1]};
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end else if (timeout) begin
            rx_err_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
`ifdef PS2_TX_EN
        // start bit is driven on leaving inhibit so clk_oe spans exactly INH_CYC cycles
        S_TX_INH: begin
          if (inh_q == IW'(INH_CYC - 1)) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b1;
            state_q  <= S_TX_START;
          end else begin
            inh_q <= inh_q + IW'(1);
          end
        end
        S_TX_START: begin
          bitcnt_q <= '0;
          state_q  <= S_TX_BITS;
        end
        S_TX_BITS: begin
          if (fe) begin
            if (bitcnt_q == 4'd9) begin
              dat_oe_q <= 1'b0;
              state_q  <= S_TX_ACK;
            end else begin
              dat_oe_q <= ~tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[8:1]};
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end else if (timeout) begin
            dat_oe_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            ack_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_TX_ACK: begin
          if (fe) begin
            ack_err_q <= dat_s;
            state_q   <= S_IDLE;
          end else if (timeout) begin
            dat_oe_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            ack_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_error = rx_err_q;

`ifdef PS2_TX_EN
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = (state_q == S_IDLE);
  assign tx_ack_err = ack_err_q;
`else
  logic unused_tx;
  assign unused_tx  = ^{tx_data, tx_valid};
  assign ps2_clk_oe = 1'b0;
  assign ps2_dat_oe = 1'b0;
  assign tx_ready   = 1'b0;
  assign tx_ack_err = 1'b0;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q, pop, full, wr;

  always_comb begin
    pop  = (cnt_q != '0) && rx_ready;
    full = (cnt_q == (AW+1)'(FIFO_DEPTH));
    wr   = frame_good && (!full || pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wptr_q] <= rx_sh_q[7:0];
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (wr && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!wr && pop) cnt_q <= cnt_q - (AW+1)'(1);
      ovf_q <= (frame_good && full && !pop) || (ovf_q && !ovf_clr);
    end
  end

  assign rx_data     = mem_q[rptr_q];
  assign rx_valid    = (cnt_q != '0);
  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Randomized PS/2 device model against a queue-based reference of the host controller.
module tb_ps2_host_ctrl;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TO_US  = 300;
  localparam int          TO     = TO_US * (CLK_HZ / 1000) / 1000;
  localparam int          INH    = CLK_HZ / 10000;
  localparam int          HALF   = 40;
`ifdef PS2_TX_EN
  localparam bit TXRDY = 1'b1;
`else
  localparam bit TXRDY = 1'b0;
`endif

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
  logic [7:0] rx_data, tx_data = 8'h00;
  logic       rx_valid, rx_ready = 1'b0, rx_error, rx_overflow, ovf_clr = 1'b0;
  logic       tx_valid = 1'b0, tx_ready, tx_ack_err;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  ps2_host_ctrl #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .TIMEOUT_US(TO_US)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_error(rx_error),
    .rx_overflow(rx_overflow), .ovf_clr(ovf_clr), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_ack_err(tx_ack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  int   n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];
  bit   m_ovf = 1'b0;
  int   exp_err = 0, exp_ack = 0, rx_err_seen = 0, ack_err_seen = 0;
  int   cyc = 0, fall_cyc = 0, rx_lat = -1, err_lat = -1;
  bit   prev_valid = 1'b0, chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rx_error) begin rx_err_seen++; err_lat = cyc - fall_cyc; end
    if (tx_ack_err) ack_err_seen++;
    if (rx_valid && !prev_valid) rx_lat = cyc - fall_cyc;
    prev_valid = rx_valid;
    if (chk_en) begin
      check("rx_valid", rx_valid, q.size() > 0);
      if (q.size() > 0) check("rx_data", rx_data, q[0]);
      check("rx_overflow", rx_overflow, m_ovf);
      check("tx_ready", tx_ready, TXRDY);
      check("oe_idle", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      dev_dat = bits[i];
      wait_cyc(HALF);
      dev_clk = 1'b0;
      fall_cyc = cyc;
      wait_cyc(HALF);
      dev_clk = 1'b1;
    end
    wait_cyc(HALF);
    dev_dat = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    chk_en = 1'b0;
    par = ~^b ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    wait_cyc(20);
    if (bad_par || bad_stop)   exp_err++;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else                        q.push_back(b);
    check("rx_err_count", rx_err_seen, exp_err);
    chk_en = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk);
    if (q.size() == 0) return;
    rx_ready = 1'b1;
    @(posedge clk);
    void'(q.pop_front());
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(posedge clk);
    m_ovf = 1'b0;
    @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  task automatic reset_mid(input string name);
    chk_en = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check({name, "_oe_async"}, {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(20);
    check({name, "_tx_ready"}, tx_ready, TXRDY);
    check({name, "_rx_valid"}, rx_valid, 1'b0);
    chk_en = 1'b1;
  endtask

`ifdef PS2_TX_EN
  task automatic tx_cmd(input logic [7:0] b, input bit ack);
    int n;
    logic [9:0] expb;
    chk_en = 1'b0;
    expb = {1'b1, ~^b, b};
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 5000) begin n++; @(negedge clk); end
    check("tx_inhibit_cycles", n, INH);
    check("tx_start_bit", ps2_dat_oe, 1'b1);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) dev_dat = !ack;
      wait_cyc(HALF);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      if (i < 10) check("tx_bit", ps2_dat_i, expb[i]);
      dev_clk = 1'b1;
    end
    wait_cyc(HALF);
    dev_dat = 1'b1;
    wait_cyc(20);
    if (!ack) exp_ack++;
    check("tx_ack_err_count", ack_err_seen, exp_ack);
    chk_en = 1'b1;
  endtask
`endif

  logic [7:0] ovf_lit [4] = '{8'h11, 8'h12, 8'h13, 8'h14};

  initial begin
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(3);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_errors", {rx_error, rx_overflow, tx_ack_err}, 3'b000);
    check("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("reset_tx_ready", tx_ready, TXRDY);
    chk_en = 1'b1;

    rx_frame(8'h1C, 1'b0, 1'b0);
    check("lit_head_1C", rx_data, 8'h1C);
    check("rx_latency", (rx_lat >= 10 && rx_lat <= 11), 1'b1);
    pop_one();

    rx_frame(8'hF0, 1'b1, 1'b0);
    check("lit_parity_err", rx_err_seen, 1);
    check("lit_parity_novalid", rx_valid, 1'b0);

    for (int i = 0; i < 5; i++) rx_frame(8'h11 + 8'(i), 1'b0, 1'b0);
    check("lit_overflow", rx_overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_ovf_pop", rx_data, ovf_lit[i]);
      pop_one();
    end
    wait_cyc(2);
    check("lit_ovf_empty", rx_valid, 1'b0);
    clear_ovf();
    wait_cyc(2);
    check("lit_ovf_clr", rx_overflow, 1'b0);

    chk_en = 1'b0;
    send_bits(11'b000_0101_0100, 5);
    wait_cyc(TO + 100);
    exp_err++;
    check("timeout_err_count", rx_err_seen, exp_err);
    check("timeout_latency", (err_lat >= TO + 8 && err_lat <= TO + 14), 1'b1);
    chk_en = 1'b1;
    rx_frame(8'h29, 1'b0, 1'b0);
    check("lit_after_timeout", rx_data, 8'h29);
    pop_one();

    for (int it = 0; it < 30; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5)      rx_frame(8'($urandom), r == 4, r == 5);
      else if (r <= 8) repeat ($urandom_range(1, 3)) pop_one();
      else             clear_ovf();
    end
    while (q.size() > 0) pop_one();

    chk_en = 1'b0;
    send_bits(11'b111_1111_0010, 4);
    reset_mid("reset_rx");
    rx_frame(8'h5A, 1'b0, 1'b0);
    pop_one();

`ifdef PS2_TX_EN
    tx_cmd(8'hED, 1'b1);
    tx_cmd(8'h3C, 1'b0);
    tx_cmd(8'($urandom), 1'b1);

    chk_en = 1'b0;
    @(negedge clk);
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_cyc(20);
    check("inh_active", ps2_clk_oe, 1'b1);
    reset_mid("reset_inh");

    chk_en = 1'b0;
    @(negedge clk);
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int n = 0; n < 5000 && ps2_clk_oe; n++) @(negedge clk);
    check("start_active", ps2_dat_oe, 1'b1);
    reset_mid("reset_tx");
`else
    chk_en = 1'b0;
    @(negedge clk);
    tx_data = 8'hED; tx_valid = 1'b1;
    wait_cyc(150);
    check("txdis_ready", tx_ready, 1'b0);
    check("txdis_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("txdis_ack_err", ack_err_seen, 0);
    tx_valid = 1'b0;
    chk_en = 1'b1;
`endif

    rx_frame(8'h29, 1'b0, 1'b0);
    wait_cyc(5);
    check("final_rx_err_count", rx_err_seen, exp_err);
    check("final_ack_err_count", ack_err_seen, exp_ack);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
